// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the wait-state memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } resp_state_e;

  localparam int unsigned WORD_BYTES = 4;

  // Word-index width for a power-of-two depth.
  function automatic int unsigned idxWidth(input int unsigned depthWords);
    return $clog2(depthWords);
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port word RAM: synchronous write, combinational read of the addressed word.
module mem_word_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = 8
) (
  input  logic             Clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge Clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Word-access memory responder with configurable wait states and a one-cycle Ack.
// Define MEM_RANGE_CHECK_EN to add RangeErr for addresses beyond the array instead of wrapping.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic              Wr,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              Ack,
  output logic              Busy,
  output logic              Misaligned
`ifdef MEM_RANGE_CHECK_EN
  ,
  output logic              RangeErr
`endif
);

  localparam int unsigned IdxW     = idxWidth(DEPTH_WORDS);
  localparam logic [3:0]  WaitInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  resp_state_e       stateQ, stateD;
  logic [3:0]        cntQ, cntD;
  logic              accept;
  logic              wrQ;
  logic [ADDR_W-1:0] addrQ;
  logic [31:0]       dataQ;
  logic [31:0]       dataOutQ;
  logic              misQ;

  logic              accWr;
  logic [ADDR_W-1:0] accAddr;
  logic [31:0]       accData;
  logic              accMis;
  logic              accRange;
  logic              enterResp;
  logic              we;
  logic [IdxW-1:0]   idx;
  logic [31:0]       rdata;

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    accept = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (Req) begin
          accept = 1'b1;
          if (WAIT_STATES > 0) begin
            stateD = StWait;
            cntD   = WaitInit;
          end else begin
            stateD = StResp;
          end
        end
      end
      StWait: begin
        if (cntQ == 4'd0) begin
          stateD = StResp;
        end else begin
          cntD = cntQ - 4'd1;
        end
      end
      StResp:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  // With zero wait states the access shares the acceptance edge, so use the live inputs.
  assign accWr     = (stateQ == StIdle) ? Wr      : wrQ;
  assign accAddr   = (stateQ == StIdle) ? Address : addrQ;
  assign accData   = (stateQ == StIdle) ? DataIn  : dataQ;
  assign accMis    = (accAddr[1:0] != 2'b00);
  assign idx       = accAddr[IdxW+1:2];
  assign enterResp = (stateD == StResp) && (stateQ != StResp);

`ifdef MEM_RANGE_CHECK_EN
  localparam logic [ADDR_W:0] AddrLimit = (ADDR_W + 1)'(DEPTH_WORDS * WORD_BYTES);
  logic rangeQ;
  assign accRange = ({1'b0, accAddr} >= AddrLimit);
  assign RangeErr = rangeQ;
`else
  logic unusedAddrBits;
  assign accRange       = 1'b0;
  assign unusedAddrBits = ^accAddr[ADDR_W-1:IdxW+2];
`endif

  // Reset gates the write so an access racing an asserted reset never lands.
  assign we = enterResp && accWr && !accMis && !accRange && Reset;

  mem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IdxW)
  ) u_array (
    .Clk  (Clk),
    .we   (we),
    .idx  (idx),
    .wdata(accData),
    .rdata(rdata)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stateQ   <= StIdle;
      cntQ     <= 4'd0;
      wrQ      <= 1'b0;
      addrQ    <= '0;
      dataQ    <= 32'd0;
      dataOutQ <= 32'd0;
      misQ     <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
      rangeQ   <= 1'b0;
`endif
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      if (accept) begin
        wrQ   <= Wr;
        addrQ <= Address;
        dataQ <= DataIn;
        misQ  <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
        rangeQ <= 1'b0;
`endif
      end
      if (enterResp) begin
        misQ <= accMis;
`ifdef MEM_RANGE_CHECK_EN
        rangeQ <= accRange;
`endif
        if (accMis || accRange) begin
          dataOutQ <= 32'd0;
        end else if (!accWr) begin
          dataOutQ <= rdata;
        end
      end
    end
  end

  assign DataOut    = dataOutQ;
  assign Ack        = (stateQ == StResp);
  assign Busy       = (stateQ != StIdle);
  assign Misaligned = misQ;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at 1, 0 and 3 wait states with a response scoreboard.
module tb_mem_responder;

  typedef struct packed {
    logic [31:0] dout;
    logic        mis;
    logic        rerr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN [3];
  logic        req  [3];
  logic        wr   [3];
  logic [31:0] addr [3];
  logic [31:0] din  [3];
  logic [31:0] dout [3];
  logic        ack  [3];
  logic        busy [3];
  logic        mis  [3];
  logic        rerr [3];

  int total = 0;
  int bad   = 0;

  exp_t        sb [$];
  logic [31:0] model    [3][256];
  logic [31:0] lastDout [3];

  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int unsigned Ws = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    mem_responder #(
      .DEPTH_WORDS(256),
      .WAIT_STATES(Ws),
      .ADDR_W     (32)
    ) u_dut (
      .Clk       (clk),
      .Reset     (rstN[g]),
      .Req       (req[g]),
      .Wr        (wr[g]),
      .Address   (addr[g]),
      .DataIn    (din[g]),
      .DataOut   (dout[g]),
      .Ack       (ack[g]),
      .Busy      (busy[g]),
      .Misaligned(mis[g])
`ifdef MEM_RANGE_CHECK_EN
      ,
      .RangeErr  (rerr[g])
`endif
    );
`ifndef MEM_RANGE_CHECK_EN
    assign rerr[g] = 1'b0;
`endif
  end

  function automatic int wsOf(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  task automatic checkIdle(input int d, input string tag);
    check({tag, "_ack"}, 32'(ack[d]), 32'd0);
    check({tag, "_busy"}, 32'(busy[d]), 32'd0);
    check({tag, "_dout"}, dout[d], 32'd0);
    check({tag, "_mis"}, 32'(mis[d]), 32'd0);
  endtask

  // One access: model computes the expected response, DUT completion pops it.
  task automatic access(input int d, input bit w, input logic [31:0] a, input logic [31:0] data,
                        input bit churn);
    exp_t       e;
    int         lat;
    bit         got;
    logic [7:0] ix;
    ix     = a[9:2];
    e.mis  = (a[1:0] != 2'b00);
    e.rerr = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
    e.rerr = (a >= 32'd1024);
`endif
    if (e.mis || e.rerr) lastDout[d] = 32'd0;
    else if (w) model[d][ix] = data;
    else lastDout[d] = model[d][ix];
    e.dout = lastDout[d];
    sb.push_back(e);

    @(negedge clk);
    req[d] = 1'b1; wr[d] = w; addr[d] = a; din[d] = data;
    @(posedge clk);
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ack[d]) begin
        got = 1'b1;
        req[d] = 1'b0;
      end else begin
        req[d] = churn ? 1'($urandom_range(0, 1)) : 1'b0;
        if (churn) begin
          wr[d]   = 1'($urandom_range(0, 1));
          addr[d] = $urandom;
          din[d]  = $urandom;
        end
        @(posedge clk);
        lat++;
      end
    end
    req[d] = 1'b0;
    check("ack_seen", 32'(ack[d]), 32'd1);
    e = sb.pop_front();
    if (got) begin
      check("latency", 32'(lat), 32'(wsOf(d) + 1));
      check("dout", dout[d], e.dout);
      check("mis", 32'(mis[d]), 32'(e.mis));
      check("rerr", 32'(rerr[d]), 32'(e.rerr));
      check("busy_resp", 32'(busy[d]), 32'd1);
      @(negedge clk);
      check("ack_pulse", 32'(ack[d]), 32'd0);
      check("busy_idle", 32'(busy[d]), 32'd0);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rstN[d] = 1'b0; req[d] = 1'b0; wr[d] = 1'b0; addr[d] = 32'd0; din[d] = 32'd0;
      lastDout[d] = 32'd0;
    end
    #12;
    for (int d = 0; d < 3; d++) checkIdle(d, "reset");
    @(negedge clk);
    for (int d = 0; d < 3; d++) rstN[d] = 1'b1;

    // One wait state: write/read, misaligned, wrap or range error.
    access(0, 1'b1, 32'h20, 32'h12345678, 1'b0);
    access(0, 1'b0, 32'h20, 32'h0, 1'b0);
    access(0, 1'b1, 32'h22, 32'hFFFFFFFF, 1'b0);
    access(0, 1'b0, 32'h20, 32'h0, 1'b0);
    access(0, 1'b1, 32'h004, 32'h00000BAD, 1'b0);
    access(0, 1'b1, 32'h404, 32'hA5A5A5A5, 1'b0);
    access(0, 1'b0, 32'h004, 32'h0, 1'b0);

    // Zero wait states: single accesses, then back-to-back with Req held.
    access(1, 1'b1, 32'h20, 32'h5A5A0001, 1'b0);
    access(1, 1'b0, 32'h20, 32'h0, 1'b0);
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h20;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_ack", 32'(ack[1]), 32'((i % 2) == 0));
      check("b2b_busy", 32'(busy[1]), 32'((i % 2) == 0));
      check("b2b_dout", dout[1], 32'h5A5A0001);
    end
    req[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Three wait states: abandoned write under reset, then captured-input churn.
    access(2, 1'b1, 32'h10, 32'h11111111, 1'b0);
    @(negedge clk);
    req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'h10; din[2] = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    req[2] = 1'b0;
    check("wait_busy", 32'(busy[2]), 32'd1);
    rstN[2] = 1'b0;
    #1;
    checkIdle(2, "midwait");
    @(negedge clk);
    checkIdle(2, "held");
    @(negedge clk);
    rstN[2] = 1'b1;
    lastDout[2] = 32'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_ack_after_rst", 32'(ack[2]), 32'd0);
    end
    access(2, 1'b0, 32'h10, 32'h0, 1'b0);
    access(2, 1'b1, 32'h30, 32'hCAFEF00D, 1'b1);
    access(2, 1'b0, 32'h30, 32'h0, 1'b0);
    access(2, 1'b0, 32'h10, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
